// File: rtl/i2s_rx_word_packer.sv
// I2S RX word packer: gathers right-aligned samples from the channel receiver
// into 32-bit words (4x8 or 2x16 when packing, otherwise one sample per word)
// and buffers them in a 4-deep first-word-fall-through FIFO for the uDMA.
// Optional feature macro: I2S_RX_PACKER_SIGN_EXT_EN -- when defined, unpacked
// samples are sign-extended into bits 31:W instead of zero-extended.
module i2s_rx_word_packer (
  input  logic        sck_i,
  input  logic        rstn_i,
  input  logic        cfg_en_i,
  input  logic        cfg_pack_i,
  input  logic [4:0]  cfg_num_bits_i,
  input  logic [31:0] in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [31:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        overflow_o,
  output logic [2:0]  level_o
);

  logic [1:0]  slot_q, slot_d;
  logic [31:0] part_q, part_d;
  logic        ovf_q, ovf_d;
  logic [31:0] mem_q [4];
  logic [1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [2:0]  level_q, level_d;

  logic [1:0]  last_slot;
  logic [4:0]  shamt;
  logic [31:0] mask, sample, packed_word;
  logic        accept, push, pop;

  // Gate with rstn_i so in_ready drops the instant reset is asserted.
  assign in_ready_o  = rstn_i & cfg_en_i & (level_q < 3'd4);
  assign out_valid_o = (level_q != 3'd0);
  assign out_data_o  = mem_q[rd_q];
  assign overflow_o  = ovf_q;
  assign level_o     = level_q;

  assign accept = in_valid_i & in_ready_o;
  assign push   = accept & (slot_q == last_slot);
  assign pop    = out_valid_o & out_ready_i & cfg_en_i;

  // Packing factor (as last slot index), slot bit offset and masked sample.
  always_comb begin
    last_slot = 2'd0;
    if (cfg_pack_i && cfg_num_bits_i == 5'd7)       last_slot = 2'd3;
    else if (cfg_pack_i && cfg_num_bits_i == 5'd15) last_slot = 2'd1;
    case (last_slot)
      2'd3:    shamt = {slot_q, 3'b000};
      2'd1:    shamt = {slot_q[0], 4'b0000};
      default: shamt = 5'd0;
    endcase
    mask   = 32'hFFFF_FFFF >> (5'd31 - cfg_num_bits_i);
    sample = in_data_i & mask;
`ifdef I2S_RX_PACKER_SIGN_EXT_EN
    if (last_slot == 2'd0 && in_data_i[cfg_num_bits_i]) sample = sample | ~mask;
`else
`endif
    packed_word = part_q | (sample << shamt);
  end

  // Slot counter, partial word and sticky overflow next state.
  always_comb begin
    slot_d = slot_q;
    part_d = part_q;
    ovf_d  = ovf_q;
    if (!cfg_en_i) begin
      slot_d = 2'd0;
      part_d = '0;
      ovf_d  = 1'b0;
    end else begin
      if (in_valid_i && !in_ready_o) ovf_d = 1'b1;
      if (accept) begin
        if (slot_q == last_slot) begin
          slot_d = 2'd0;
          part_d = '0;
        end else begin
          slot_d = slot_q + 2'd1;
          part_d = packed_word;
        end
      end
    end
  end

  // FIFO pointer and occupancy next state; disable flushes everything.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (!cfg_en_i) begin
      wr_d    = 2'd0;
      rd_d    = 2'd0;
      level_d = 3'd0;
    end else begin
      if (push) wr_d = wr_q + 2'd1;
      if (pop)  rd_d = rd_q + 2'd1;
      case ({push, pop})
        2'b10:   level_d = level_q + 3'd1;
        2'b01:   level_d = level_q - 3'd1;
        default: level_d = level_q;
      endcase
    end
  end

  // Packer state registers.
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      slot_q <= 2'd0;
      part_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      slot_q <= slot_d;
      part_q <= part_d;
      ovf_q  <= ovf_d;
    end
  end

  // FIFO storage and pointers; storage is cleared so out_data reads 0 when idle.
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wr_q    <= 2'd0;
      rd_q    <= 2'd0;
      level_q <= 3'd0;
    end else begin
      if (!cfg_en_i) begin
        for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      end else if (push) begin
        mem_q[wr_q] <= packed_word;
      end
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

endmodule

// File: tb/tb_i2s_rx_word_packer.sv
// Bench for i2s_rx_word_packer: directed vector table, hand-written corner
// sequences and a randomized run, all checked against a queue-based model.
module tb_i2s_rx_word_packer;

`ifdef I2S_RX_PACKER_SIGN_EXT_EN
  localparam bit SEXT = 1'b1;
`else
  localparam bit SEXT = 1'b0;
`endif

  logic        sck_i = 1'b0;
  logic        rstn_i;
  logic        cfg_en_i, cfg_pack_i;
  logic [4:0]  cfg_num_bits_i;
  logic [31:0] in_data_i;
  logic        in_valid_i, in_ready_o;
  logic [31:0] out_data_o;
  logic        out_valid_o, out_ready_i, overflow_o;
  logic [2:0]  level_o;

  i2s_rx_word_packer dut (
    .sck_i(sck_i), .rstn_i(rstn_i), .cfg_en_i(cfg_en_i), .cfg_pack_i(cfg_pack_i),
    .cfg_num_bits_i(cfg_num_bits_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .overflow_o(overflow_o), .level_o(level_o)
  );

  always #5 sck_i = ~sck_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of completed words, queue of pending samples.
  logic [31:0] mq[$];
  logic [31:0] ms[$];
  bit          m_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pf(input logic pack, input logic [4:0] bits);
    if (pack && bits == 5'd7)  return 4;
    if (pack && bits == 5'd15) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] pack_word(input int w, input int p);
    longint unsigned acc = 0;
    longint unsigned msk = (64'd1 << w) - 1;
    logic [31:0] s0;
    for (int k = 0; k < p; k++) acc |= ({32'd0, ms[k]} & msk) << (k * w);
    s0 = ms[0];
    if (SEXT && p == 1 && s0[w-1]) acc |= ~msk;
    return acc[31:0];
  endfunction

  // Apply one cycle of inputs, check pre-edge outputs against the model,
  // advance the model, then move to just after the next rising edge.
  task automatic step(input logic en, input logic pack, input logic [4:0] bits,
                      input logic [31:0] data, input logic valid, input logic ordy);
    int  lvl;
    bit  rdy;
    int  p;
    cfg_en_i = en; cfg_pack_i = pack; cfg_num_bits_i = bits;
    in_data_i = data; in_valid_i = valid; out_ready_i = ordy;
    #1;
    lvl = mq.size();
    rdy = en && (lvl < 4);
    check("in_ready", 32'(in_ready_o), 32'(rdy));
    check("out_valid", 32'(out_valid_o), 32'(lvl != 0));
    check("level", 32'(level_o), 32'(lvl));
    check("overflow", 32'(overflow_o), 32'(m_ovf));
    if (lvl != 0) check("out_data", out_data_o, mq[0]);
    p = pf(pack, bits);
    if (!en) begin
      mq.delete(); ms.delete(); m_ovf = 1'b0;
    end else begin
      if (valid && !rdy) m_ovf = 1'b1;
      if (lvl != 0 && ordy) void'(mq.pop_front());
      if (valid && rdy) begin
        ms.push_back(data);
        if (ms.size() == p) begin
          mq.push_back(pack_word(int'(bits) + 1, p));
          ms.delete();
        end
      end
    end
    @(posedge sck_i); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready_o), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
    check({tag, "_out_data"}, out_data_o, 32'd0);
    check({tag, "_overflow"}, 32'(overflow_o), 32'd0);
    check({tag, "_level"}, 32'(level_o), 32'd0);
  endtask

  typedef struct {
    logic        en, pack;
    logic [4:0]  bits;
    logic [31:0] data;
    logic        valid, ordy;
    int          exp_level;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt[14];
  logic [31:0] d[5];
  logic [4:0]  bt[4];
  logic        r_en, r_pack;
  logic [4:0]  r_bits;

  initial begin
    localparam logic [31:0] SX_EXP = SEXT ? 32'hFF80_0001 : 32'h0080_0001;
    vt[0]  = '{1, 1, 7,  32'h0000_0011, 1, 0, 0, 32'h0};
    vt[1]  = '{1, 1, 7,  32'h5A5A_5A22, 1, 0, 0, 32'h0};
    vt[2]  = '{1, 1, 7,  32'h0000_0033, 1, 0, 0, 32'h0};
    vt[3]  = '{1, 1, 7,  32'h0000_0044, 1, 0, 1, 32'h4433_2211};
    vt[4]  = '{0, 1, 15, 32'h0,         0, 0, 0, 32'h0};
    vt[5]  = '{1, 1, 15, 32'h0000_AAAA, 1, 0, 0, 32'h0};
    vt[6]  = '{1, 1, 15, 32'h0000_5555, 1, 0, 1, 32'h5555_AAAA};
    vt[7]  = '{1, 1, 15, 32'h0000_1234, 1, 0, 1, 32'h5555_AAAA};
    vt[8]  = '{1, 1, 15, 32'h0000_BEEF, 1, 0, 2, 32'h5555_AAAA};
    vt[9]  = '{1, 1, 15, 32'h0,         0, 1, 1, 32'hBEEF_1234};
    vt[10] = '{1, 1, 15, 32'h0,         0, 1, 0, 32'h0};
    vt[11] = '{0, 0, 23, 32'h0,         0, 0, 0, 32'h0};
    vt[12] = '{1, 0, 23, 32'h0080_0001, 1, 0, 1, SX_EXP};
    vt[13] = '{1, 0, 23, 32'h0,         0, 1, 0, 32'h0};
    bt[0] = 5'd7; bt[1] = 5'd15; bt[2] = 5'd23; bt[3] = 5'd31;

    // Reset with enable already high: in_ready must still be forced low.
    rstn_i = 1'b0; cfg_en_i = 1'b1; cfg_pack_i = 1'b0; cfg_num_bits_i = 5'd31;
    in_data_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    #3;
    check_reset_outputs("reset");
    cfg_en_i = 1'b0;
    #4 rstn_i = 1'b1;
    @(posedge sck_i); #1;

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      step(vt[i].en, vt[i].pack, vt[i].bits, vt[i].data, vt[i].valid, vt[i].ordy);
      check($sformatf("vec%0d_level", i), 32'(level_o), 32'(vt[i].exp_level));
      check($sformatf("vec%0d_valid", i), 32'(out_valid_o), 32'(vt[i].exp_level != 0));
      if (vt[i].exp_level != 0) check($sformatf("vec%0d_data", i), out_data_o, vt[i].exp_data);
    end

    // Overflow: fill with no consumer, fifth sample is dropped.
    step(0, 0, 31, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      d[i] = $urandom;
      step(1, 0, 31, d[i], 1, 0);
      if (i == 3) begin
        check("ovf_full_level", 32'(level_o), 32'd4);
        check("ovf_full_ready", 32'(in_ready_o), 32'd0);
        check("ovf_not_yet", 32'(overflow_o), 32'd0);
      end
    end
    check("ovf_flag", 32'(overflow_o), 32'd1);
    check("ovf_level_kept", 32'(level_o), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_drain%0d", i), out_data_o, d[i]);
      step(1, 0, 31, 0, 0, 1);
    end
    check("ovf_drained", 32'(level_o), 32'd0);
    check("ovf_sticky", 32'(overflow_o), 32'd1);

    // Flush mid-word: the partial word must never appear.
    step(0, 1, 7, 0, 0, 0);
    step(1, 1, 7, 32'hA1, 1, 0);
    step(1, 1, 7, 32'hB2, 1, 0);
    step(0, 1, 7, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(1, 1, 7, 32'(i), 1, 0);
    check("flush_level", 32'(level_o), 32'd1);
    check("flush_word", out_data_o, 32'h0403_0201);
    check("flush_ovf", 32'(overflow_o), 32'd0);
    step(1, 1, 7, 0, 0, 1);
    check("flush_drained", 32'(level_o), 32'd0);

    // Simultaneous push and pop at level 2.
    step(0, 0, 31, 0, 0, 0);
    step(1, 0, 31, 32'h1111_0001, 1, 0);
    step(1, 0, 31, 32'h2222_0002, 1, 0);
    check("pp_level_pre", 32'(level_o), 32'd2);
    step(1, 0, 31, 32'h3333_0003, 1, 1);
    check("pp_level", 32'(level_o), 32'd2);
    check("pp_head1", out_data_o, 32'h2222_0002);
    step(1, 0, 31, 0, 0, 1);
    check("pp_head2", out_data_o, 32'h3333_0003);
    step(1, 0, 31, 0, 0, 1);
    check("pp_empty", 32'(level_o), 32'd0);

    // Randomized run; configuration only changes while disabled.
    r_pack = 1'b1; r_bits = 5'd7;
    step(0, r_pack, r_bits, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rstn_i = 1'b0;
        #2;
        check_reset_outputs("midreset");
        mq.delete(); ms.delete(); m_ovf = 1'b0;
        cfg_en_i = 1'b0; in_valid_i = 1'b0;
        #2 rstn_i = 1'b1;
        @(posedge sck_i); #1;
      end
      r_en = ($urandom_range(0, 59) != 0);
      if (!r_en) begin
        r_pack = 1'($urandom_range(0, 1));
        r_bits = bt[$urandom_range(0, 3)];
      end
      step(r_en, r_pack, r_bits, $urandom, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_rx_word_packer.md
I2S_RX_WORD_PACKER -- requirements
Module: i2s_rx_word_packer

Interface
REQ-001 SHALL have port sck_i, input, 1: bit clock; all logic on its rising edge.
REQ-002 SHALL have port rstn_i, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port cfg_en_i, input, 1: enable; low means flush and hold idle.
REQ-004 SHALL have port cfg_pack_i, input, 1: 1 = pack narrow samples into 32-bit words.
REQ-005 SHALL have port cfg_num_bits_i, input, 5: sample width minus 1 (legal values 7, 15, 23, 31).
REQ-006 SHALL have port in_data_i, input, 32: right-aligned sample from the channel receiver.
REQ-007 SHALL have port in_valid_i, input, 1: sample present.
REQ-008 SHALL have port in_ready_o, output, 1: sample accepted when high together with in_valid_i.
REQ-009 SHALL have port out_data_o, output, 32: packed word to the uDMA RX FIFO.
REQ-010 SHALL have port out_valid_o, output, 1: output word valid.
REQ-011 SHALL have port out_ready_i, input, 1: consumer accepts the word.
REQ-012 SHALL have port overflow_o, output, 1: sticky flag, sample dropped.
REQ-013 SHALL have port level_o, output, 3: output FIFO occupancy, 0..4.

Function
REQ-014 SHALL use a packing factor P: 4 when cfg_pack_i=1 and width=8; 2 when cfg_pack_i=1 and width=16; 1 otherwise.
REQ-015 SHALL place slot k (k=0..P-1) at bits [k*W+W-1 : k*W], where W = cfg_num_bits_i+1, so the first received sample occupies the LSBs.
REQ-016 SHALL use a slot counter of 0..P-1, incremented per accepted sample; on slot P-1 it SHALL wrap to 0 and push the completed word into the FIFO in the same edge.
REQ-017 SHALL zero unused upper bits of a packed word.
REQ-018 SHALL implement the output FIFO as 4 x 32 bits, first-word-fall-through, with out_data_o driven by the head entry.
REQ-019 SHALL drive in_ready_o = cfg_en_i AND (level_o < 4).
REQ-020 SHALL drop a sample when in_valid_i=1 and in_ready_o=0 with cfg_en_i=1, set overflow_o the next edge, and leave slot and FIFO contents unchanged.
REQ-021 SHALL give a latency of one edge from the accepted final slot to out_valid_o=1, with no combinational bypass from in_* to out_*.
REQ-022 SHALL pop the FIFO on out_valid_o AND out_ready_i.
REQ-023 SHALL, on a simultaneous push and pop, leave level unchanged and preserve data order.
REQ-024 SHALL, when the FIFO is full and a pop occurs, accept no push in that cycle, because in_ready_o is already 0.
REQ-025 SHALL drive out_valid_o = (level_o != 0).
REQ-026 SHALL, while cfg_en_i=0, at each edge clear the FIFO, the slot counter, the partial word and overflow_o, and hold out_valid_o=0 from the next edge.
REQ-027 SHALL, when cfg_en_i drops mid-word, discard the partial word without emitting it.
REQ-028 SHALL leave behaviour undefined if cfg_pack_i or cfg_num_bits_i changes while cfg_en_i=1.

Reset
REQ-029 SHALL, on rstn_i low, immediately force in_ready_o=0, out_valid_o=0, out_data_o=0, overflow_o=0, level_o=0, slot=0, partial word=0.
REQ-030 SHALL, on rstn_i low mid-operation, lose all buffered data.
REQ-031 SHALL resume normal operation on the first sck_i rising edge after reset release.

Configuration
REQ-032 SHALL support the macro I2S_RX_PACKER_SIGN_EXT_EN.
REQ-033 SHALL, with I2S_RX_PACKER_SIGN_EXT_EN defined and P=1, sign-extend bit W-1 of the sample into bits 31:W.
REQ-034 SHALL, without I2S_RX_PACKER_SIGN_EXT_EN, zero-extend bits 31:W.
REQ-035 SHALL not apply sign extension for P>1.

Verification
REQ-036 SHALL verify 8-bit packing: pack=1, bits=7, samples 0x11,0x22,0x33,0x44 -> one word 0x44332211, out_valid_o one edge after the 4th sample.
REQ-037 SHALL verify 16-bit packing: pack=1, bits=15, samples 0xAAAA,0x5555,0x1234,0xBEEF -> words 0x5555AAAA then 0xBEEF1234, in order.
REQ-038 SHALL verify overflow: pack=0, bits=31, out_ready_i=0, 5 samples -> level_o=4, in_ready_o=0, 5th sample dropped, overflow_o=1; drain -> first 4 samples in order.
REQ-039 SHALL verify sign extension: pack=0, bits=23, sample 0x00800001 -> 0xFF800001 with the macro, 0x00800001 without.
REQ-040 SHALL verify flush: pack=1, bits=7, 2 samples then cfg_en_i=0 for one edge, then re-enable and send 4 samples -> only the new 4-sample word emitted, overflow_o=0.
REQ-041 SHALL verify simultaneous push and pop: level=2, push and pop on the same edge -> level stays 2 and order is preserved.
